// File: rtl/rv_regfile_sb.sv
// Register file with NRD read ports, write-through bypass, hardwired-zero x0 and a
// per-register busy scoreboard that holds a read until its pending producer writes back.
module rv_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD-1:0]        rd_req,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_valid,
  output logic [NRD-1:0]        rd_stall,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  claim_en,
  input  logic [ADDR_W-1:0]     claim_addr,
  output logic [NREGS-1:0]      busy_vec
);

  // Handshake: rd_req is a one-cycle pulse accepted only while rd_stall[i]=0; the
  // answer is a one-cycle rd_valid pulse, and rd_data holds its value in between.
  typedef enum logic {S_IDLE, S_WAIT} port_state_t;

  logic [XLEN-1:0]   regs [NREGS];
  logic [NREGS-1:0]  busy_q;
  port_state_t       state_q   [NRD];
  logic [ADDR_W-1:0] wait_addr [NRD];
  logic [ADDR_W-1:0] port_addr [NRD];
  logic              wr_hit;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && (32'(a) < NREGS);
  endfunction

  assign wr_hit   = wr_en && addr_ok(wr_addr);
  assign busy_vec = busy_q;

  for (genvar g = 0; g < NRD; g++) begin : g_addr
    assign port_addr[g] = rd_addr[g*ADDR_W +: ADDR_W];
  end

  // Storage and scoreboard; a claim in the same cycle as the write-back keeps the bit set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_hit) regs[wr_addr] <= wr_data;
      busy_q[0] <= 1'b0;
      for (int r = 1; r < NREGS; r++) begin
        if (claim_en && claim_addr == ADDR_W'(r))
          busy_q[r] <= 1'b1;
        else if (wr_hit && wr_addr == ADDR_W'(r))
          busy_q[r] <= 1'b0;
      end
    end
  end

  // Per-port read FSM; rd_stall mirrors the S_WAIT state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= '0;
      rd_stall <= '0;
      for (int i = 0; i < NRD; i++) begin
        state_q[i]   <= S_IDLE;
        wait_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NRD; i++) begin
        rd_valid[i] <= 1'b0;
        case (state_q[i])
          S_IDLE: begin
            if (rd_req[i]) begin
              if (!addr_ok(port_addr[i])) begin
                rd_data[i*XLEN +: XLEN] <= '0;
                rd_valid[i]             <= 1'b1;
              end else if (wr_hit && wr_addr == port_addr[i]) begin
                rd_data[i*XLEN +: XLEN] <= wr_data;
                rd_valid[i]             <= 1'b1;
              end else if (!busy_q[port_addr[i]]) begin
                rd_data[i*XLEN +: XLEN] <= regs[port_addr[i]];
                rd_valid[i]             <= 1'b1;
              end else begin
                wait_addr[i] <= port_addr[i];
                state_q[i]   <= S_WAIT;
                rd_stall[i]  <= 1'b1;
              end
            end
          end
          S_WAIT: begin
            if (wr_hit && wr_addr == wait_addr[i]) begin
              rd_data[i*XLEN +: XLEN] <= wr_data;
              rd_valid[i]             <= 1'b1;
              rd_stall[i]             <= 1'b0;
              state_q[i]              <= S_IDLE;
            end
          end
          default: begin
            state_q[i]  <= S_IDLE;
            rd_stall[i] <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/rv_regfile_sb.md
Name: rv_regfile_sb

Overview:
Parametrised register file with an integrated per-register busy scoreboard. It is the next-generation register file for the multi-cycle RV32 core. It serves NRD independent read ports with 1-cycle latency, write-through bypass and a hardwired-zero x0. It holds a read until the pending producer writes back, so the control FSM no longer sequences around multi-cycle results by hand.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (2..2^ADDR_W)
ADDR_W, 5, register address width
NRD, 2, number of read ports (1..4)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
rd_req  input  NRD  per-port read request, one-cycle pulse
rd_addr  input  NRD*ADDR_W  per-port read address, port i at [i*ADDR_W +: ADDR_W]
rd_data  output  NRD*XLEN  per-port read data, port i at [i*XLEN +: XLEN]
rd_valid  output  NRD  per-port read data valid, one-cycle pulse
rd_stall  output  NRD  port i is waiting on a busy register
wr_en  input  1  write-back enable
wr_addr  input  ADDR_W  write-back address
wr_data  input  XLEN  write-back data
claim_en  input  1  mark a destination register busy (issue of a multi-cycle op)
claim_addr  input  ADDR_W  register to mark busy
busy_vec  output  NREGS  registered scoreboard, bit r = register r busy

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers = 0, busy_vec = 0
  - rd_data = 0, rd_valid = 0, rd_stall = 0
  - all ports IDLE
  - reset asserted mid-WAIT aborts the read; no rd_valid is produced after release.
- Register 0 and addresses >= NREGS:
  - reads return 0 and are never stalled
  - writes and claims to them are ignored; their busy bit does not exist or stays 0.
- Write: when wr_en=1 and the address is valid and nonzero, regs[wr_addr] <= wr_data at the edge, and busy[wr_addr] is cleared.
- Claim: when claim_en=1 and the address is valid and nonzero, busy[claim_addr] is set at the edge.
- Claim and write to the same address in the same cycle: the register is written and busy stays set (claim wins; back-to-back producer).
- Per-port FSM, states IDLE and WAIT:
  - IDLE, rd_req=1. The busy check uses the registered busy_vec, so a same-cycle claim is not visible. Cases are checked in order:
    a) wr_en=1 to the same nonzero address: bypass. rd_data <= wr_data, rd_valid=1 next cycle, whether or not the register is busy.
    b) register not busy: rd_data <= regs[addr], rd_valid=1 next cycle.
    c) register busy: latch the address, go to WAIT, rd_stall=1 from the next cycle; rd_valid stays 0.
  - WAIT:
    - rd_req is ignored (requester must hold off while rd_stall=1).
    - On wr_en=1 to the latched address: rd_data <= wr_data, rd_valid=1 and rd_stall=0 next cycle, return to IDLE.
    - A write to another address has no effect on the port.
  - rd_valid is a single-cycle pulse. rd_data holds its last value when rd_valid=0.
- Latency:
  - non-busy read: data valid exactly 1 cycle after rd_req
  - stalled read: data valid exactly 1 cycle after the releasing write
- Ports are fully independent. Multiple ports may wait on the same register, and all are released by the same write in the same cycle.
- Outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- Reset, then write x5=0x12345678; next cycle read port0 x5 -> rd_valid[0]=1 one cycle later, rd_data0=0x12345678; busy_vec=0.
- Write x0=0xFFFFFFFF and claim x0; read x0 on both ports -> rd_data=0 on both, rd_stall=0, busy_vec[0]=0.
- Same cycle: rd_req port1 x7 and wr_en x7=0xA5A5A5A5 (x7 previously 0x1) -> rd_data1=0xA5A5A5A5 next cycle.
- Claim x3; next cycle port0 and port1 both read x3 -> rd_stall=2'b11, no rd_valid. Wait 3 cycles, then write x3=0xDEADBEEF -> next cycle rd_valid=2'b11, both rd_data=0xDEADBEEF, rd_stall=0, busy_vec[3]=0.
- Claim x4 and write x4=0x55 in the same cycle -> busy_vec[4]=1. A read of x4 stalls. A later write x4=0x66 releases the read with 0x66.
- Claim x9; port0 reads x9 and enters WAIT; assert rst low for 1 cycle -> rd_stall=0, busy_vec=0, x9=0. A later write x9=0x1 produces no rd_valid on port0.
